// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared CPU encodings for control fields and pipeline helpers
package id_ex_pipe_pkg;

   // ResultSrc selects what the writeback stage returns to the register file
   localparam logic [1:0] RESULT_ALU  = 2'b00;
   localparam logic [1:0] RESULT_MEM  = 2'b01;
   localparam logic [1:0] RESULT_PC4  = 2'b10;

   // ALUControl operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam int         BUBBLE_CNT_WIDTH = 16;
   localparam logic [BUBBLE_CNT_WIDTH-1:0] BUBBLE_CNT_MAX = '1;

   // A producer whose result only arrives from memory is the one EX cannot forward in time
   function automatic logic is_load(input logic [1:0] result_src);
      return (result_src == RESULT_MEM);
   endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// rtl/id_ex_pipe_hazard_detect.sv - combinational load-use hazard detection
import id_ex_pipe_pkg::*;

module hazard_detect (
   input  logic       ValidE,
   input  logic       RegWriteE,
   input  logic [1:0] ResultSrcE,
   input  logic [4:0] RdE,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic       FlushE,
   output logic       LoadUse,
   output logic       StallF,
   output logic       StallD
);

   // x0 is never a real destination, so a zero RdE can never create a hazard
   always_comb begin
      LoadUse = ValidE & RegWriteE & is_load(ResultSrcE) & (RdE != 5'd0)
              & ((RdE == Rs1D) | (RdE == Rs2D));
      // A flush already discards the dependent instruction, so stalling would be wasted
      StallF  = LoadUse & ~FlushE;
      StallD  = LoadUse & ~FlushE;
   end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with flush, load-use bubble insertion and bubble counter
import id_ex_pipe_pkg::*;

module id_ex_pipe #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteD,
   input  logic                  MemWriteD,
   input  logic                  JumpD,
   input  logic                  BranchD,
   input  logic                  ALUSrcD,
   input  logic                  JalrmuxSelD,
   input  logic [1:0]            ResultSrcD,
   input  logic [2:0]            ALUControlD,
   input  logic [DATA_WIDTH-1:0] RD1D,
   input  logic [DATA_WIDTH-1:0] RD2D,
   input  logic [DATA_WIDTH-1:0] PCD,
   input  logic [DATA_WIDTH-1:0] ImmExtD,
   input  logic [DATA_WIDTH-1:0] PCPlus4D,
   input  logic [4:0]            Rs1D,
   input  logic [4:0]            Rs2D,
   input  logic [4:0]            RdD,
   input  logic                  FlushE,
   output logic                  RegWriteE,
   output logic                  MemWriteE,
   output logic                  JumpE,
   output logic                  BranchE,
   output logic                  ALUSrcE,
   output logic                  JalrmuxSelE,
   output logic [1:0]            ResultSrcE,
   output logic [2:0]            ALUControlE,
   output logic [DATA_WIDTH-1:0] RD1E,
   output logic [DATA_WIDTH-1:0] RD2E,
   output logic [DATA_WIDTH-1:0] PCE,
   output logic [DATA_WIDTH-1:0] ImmExtE,
   output logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic [4:0]            Rs1E,
   output logic [4:0]            Rs2E,
   output logic [4:0]            RdE,
   output logic                  ValidE,
   output logic                  StallF,
   output logic                  StallD,
   output logic [15:0]           BubbleCnt
);

   logic                        load_use;
   logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt;

   hazard_detect u_hazard_detect (
      .ValidE     (ValidE),
      .RegWriteE  (RegWriteE),
      .ResultSrcE (ResultSrcE),
      .RdE        (RdE),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .FlushE     (FlushE),
      .LoadUse    (load_use),
      .StallF     (StallF),
      .StallD     (StallD)
   );

   assign BubbleCnt = bubble_cnt;

   // Pipeline register: flush beats load-use beats capture; both kill paths load an all-zero bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         JalrmuxSelE <= 1'b0;
         ResultSrcE  <= RESULT_ALU;
         ALUControlE <= ALU_ADD;
         RD1E        <= '0;
         RD2E        <= '0;
         PCE         <= '0;
         ImmExtE     <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         RdE         <= 5'd0;
         ValidE      <= 1'b0;
      end else if (FlushE || load_use) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         JalrmuxSelE <= 1'b0;
         ResultSrcE  <= RESULT_ALU;
         ALUControlE <= ALU_ADD;
         RD1E        <= '0;
         RD2E        <= '0;
         PCE         <= '0;
         ImmExtE     <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= 5'd0;
         Rs2E        <= 5'd0;
         RdE         <= 5'd0;
         ValidE      <= 1'b0;
      end else begin
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         JalrmuxSelE <= JalrmuxSelD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         PCE         <= PCD;
         ImmExtE     <= ImmExtD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
         ValidE      <= 1'b1;
      end
   end

   // Count only load-use bubbles, saturating; flush bubbles are branch cost, not hazard cost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (load_use && !FlushE && (bubble_cnt != BUBBLE_CNT_MAX)) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule
